// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and the I-cache.
// One request is outstanding at a time; the fetch side is the master.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch front end: owns the PC, keeps one I-cache read in flight,
// buffers the returned word for IF/ID. Optional same-cycle bypass: FETCH_BYPASS_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master imem,
  input  logic         stall,
  input  logic         jb,
  input  logic [31:0]  jb_target,
  output logic [31:0]  F_out_inst,
  output logic [31:0]  F_out_pc,
  output logic         waiting
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_RESP  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        valid_q, valid_d;

  logic        consume;
  logic        req;
  logic        bypass;
  logic [31:0] redirect_pc;

  assign redirect_pc = jb_target & 32'hFFFF_FFFC;
  assign consume     = valid_q & ~stall & ~jb;

  // rst_n gating keeps the request quiet for the whole reset interval
  assign req = rst_n & (state_q == S_REQ) & ~jb & (~valid_q | consume);

`ifdef FETCH_BYPASS_EN
  assign bypass = (state_q == S_RESP) & imem.imem_rvalid & ~valid_q & ~jb;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    buf_inst_d    = buf_inst_q;
    buf_pc_d      = buf_pc_q;
    valid_d       = valid_q;

    if (consume) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_REQ: begin
        if (req && imem.imem_ready) begin
          inflight_pc_d = pc_q;
          pc_d          = pc_q + 32'd4;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (jb) begin
          state_d = imem.imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem.imem_rvalid) begin
          state_d = S_REQ;
          // a bypassed word taken directly by decode never lands in the buffer
          if (!(bypass && !stall)) begin
            buf_inst_d = imem.imem_rdata;
            buf_pc_d   = inflight_pc_q;
            valid_d    = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (imem.imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (jb) begin
      valid_d = 1'b0;
      pc_d    = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      inflight_pc_q <= 32'h0;
      buf_inst_q    <= NOP_INST;
      buf_pc_q      <= 32'h0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      buf_inst_q    <= buf_inst_d;
      buf_pc_q      <= buf_pc_d;
      valid_q       <= valid_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  assign waiting    = ~(valid_q | bypass);
  assign F_out_inst = valid_q ? buf_inst_q : (bypass ? imem.imem_rdata : NOP_INST);
  assign F_out_pc   = valid_q ? buf_pc_q   : (bypass ? inflight_pc_q   : 32'h0);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the RV32I cache pipeline. Owns the program counter, issues one outstanding read at a time to the instruction cache, buffers the returned word, and drives the instruction/PC pair and the `waiting` hold signal into the IF/ID register. It also absorbs branch/jump redirects, including discarding a response that is already in flight.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset; bits [1:0] must be 0.
- `NOP_INST`, default `32'h0000_0013`: instruction driven while no valid word is buffered (`addi x0,x0,0`).
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `stall` input 1: decode hazard hold; the buffered instruction is not consumed.
- `jb` input 1: redirect request from execute.
- `jb_target` input 32: redirect address; bits [1:0] are ignored and treated as 0.
- `imem_req` output 1: read request to the I-cache.
- `imem_addr` output 32: request address, equal to `pc_q`.
- `imem_ready` input 1: cache accepts the request this cycle when high together with `imem_req`.
- `imem_rvalid` input 1: read data valid.
- `imem_rdata` input 32: read data.
- `F_out_inst` output 32: instruction to the IF/ID register.
- `F_out_pc` output 32: PC of `F_out_inst`.
- `waiting` output 1: high when no valid instruction is offered; the IF/ID register holds.

## Operation
- **State registers:**
  - `pc_q`: next fetch address.
  - `inflight_pc`: address of the accepted request.
  - Buffer: `buf_inst`, `buf_pc`, `valid_q`.
  - FSM with states `S_REQ`, `S_RESP`, `S_DRAIN`.
- `consume = valid_q & ~stall & ~jb`.
- **Request:** `imem_req = (state==S_REQ) & ~jb & (~valid_q | consume)`.
- **`S_REQ`:**
  - When `imem_req & imem_ready`: `inflight_pc <= pc_q`, `pc_q <= pc_q + 4`, go to `S_RESP`.
  - Otherwise stay in `S_REQ`.
  - PC arithmetic is modulo 2^32; `32'hFFFF_FFFC + 4` wraps to 0.
- **`S_RESP`:**
  - When `imem_rvalid`: `buf_inst <= imem_rdata`, `buf_pc <= inflight_pc`, `valid_q <= 1`, go to `S_REQ`.
  - Otherwise stay.
- **`S_DRAIN`:**
  - When `imem_rvalid`: discard the data, go to `S_REQ`.
  - Otherwise stay.
- **Consume:** `consume` clears `valid_q`, unless a response is written into the buffer in the same cycle, in which case the buffer holds the new word.
- **Redirect (`jb=1`), in any state, overriding `stall`:**
  - `valid_q <= 0` and `pc_q <= {jb_target[31:2],2'b00}`.
  - In `S_RESP` without `imem_rvalid`: go to `S_DRAIN`.
  - In `S_RESP` with `imem_rvalid`: discard the data, go to `S_REQ`.
  - In `S_DRAIN`: stay in `S_DRAIN`; a later `jb` overwrites `pc_q` again.
  - In `S_REQ`: no request this cycle, stay in `S_REQ`.
- `imem_rvalid` in `S_REQ` is ignored.
- **Outputs:**
  - `waiting = ~valid_q`.
  - `F_out_inst = valid_q ? buf_inst : NOP_INST`.
  - `F_out_pc = valid_q ? buf_pc : 0`.
- **Reset values:**
  - `pc_q = RESET_PC`, `inflight_pc = 0`, `buf_inst = NOP_INST`, `buf_pc = 0`, `valid_q = 0`, state `S_REQ`.
  - Resulting outputs: `imem_req = 0` while `rst_n` is low, `waiting = 1`, `F_out_inst = NOP_INST`, `F_out_pc = 0`.
  - Reset asserted mid-request abandons the request; a late `imem_rvalid` arriving after release lands in `S_REQ` and is ignored.

## Timing
- First `imem_req` in the first rising edge's cycle after `rst_n` deasserts.
- Latency, registered path: acceptance at cycle t, `imem_rvalid` at t+k (k≥1), `waiting` low from t+k+1.
- Back-to-back: the next request can issue in the same cycle the buffered word is consumed.
- Peak throughput is 1 instruction per 2 cycles with k=1.
- Redirect: first request to the target is issued the cycle after `jb`, or the cycle after the drained response.
- Never more than one request outstanding.

## Configuration
- **`FETCH_BYPASS_EN` defined:**
  - Applies in `S_RESP` when `imem_rvalid & ~valid_q & ~jb`.
  - Outputs show `imem_rdata`/`inflight_pc` with `waiting=0` in the same cycle.
  - If `~stall`, the word is consumed directly and `valid_q` stays 0; if `stall`, it is written into the buffer as normal.
  - Saves one cycle of latency.
- **Not defined:** registered path only; outputs depend only on flops.

## Test plan
- **Reset:** `RESET_PC=32'h100`, `imem_ready=1`, rvalid one cycle after accept, `stall=0` -> request addresses 0x100, 0x104, 0x108; `F_out_pc` sequence 0x100, 0x104, 0x108 with `waiting` low every other cycle.
- **Stall:** `stall=1` for 3 cycles while the buffer holds the word from 0x104 -> `F_out_inst`/`F_out_pc` stable, `imem_req=0`, `pc_q` stays 0x108; fetching resumes when `stall` drops.
- **Redirect while idle:** `jb=1`, `jb_target=32'h203` while buffer valid -> `waiting=1` next cycle; next `imem_addr=32'h200`; the old buffered word is never presented again.
- **Redirect in flight:** `jb` in `S_RESP` with rvalid 2 cycles later carrying 0xDEADBEEF -> that word never appears on `F_out_inst`; the next request goes to the target.
- **Wrap and back-pressure:** start at 0xFFFF_FFFC with `imem_ready` low 4 cycles -> `imem_req` and `imem_addr` held stable; after accept the next address is 0x0.
- **Bypass:** with `FETCH_BYPASS_EN`, rvalid at t -> `waiting=0` and `F_out_inst=imem_rdata` at t; without the macro both occur at t+1.
